// File: rtl/vec_operand_loader.sv
// Packs serial (x, k) element pairs into C-lane operand vectors, then holds them and drives
// the multiplier enable until the result arrives or a timeout occurs.
module vec_operand_loader #(
    parameter int unsigned C       = 8,
    parameter int unsigned W_X     = 8,
    parameter int unsigned W_K     = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [W_X-1:0]           s_x,
    input  logic [W_K-1:0]           s_k,
    input  logic                     s_last,
    output logic [C*W_X-1:0]         x_vec,
    output logic [C*W_K-1:0]         k_vec,
    output logic                     mul_en,
    input  logic                     mul_valid,
    input  logic [W_X-1:0]           mul_y,
    output logic [W_X-1:0]           y_out,
    output logic                     y_valid,
    output logic [$clog2(C):0]       lanes_used,
    output logic                     err
);

    localparam int unsigned IW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned LW = $clog2(C) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {StFill, StIssue, StDrain} state_e;

    state_e        state;
    logic [IW-1:0] idx;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StFill;
            idx        <= '0;
            tcnt       <= '0;
            s_ready    <= 1'b0;
            x_vec      <= '0;
            k_vec      <= '0;
            mul_en     <= 1'b0;
            y_out      <= '0;
            y_valid    <= 1'b0;
            lanes_used <= '0;
            err        <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            unique case (state)
                StFill: begin
                    s_ready <= 1'b1;
                    mul_en  <= 1'b0;
                    if (s_valid && s_ready) begin
                        x_vec[idx*W_X +: W_X] <= s_x;
                        k_vec[idx*W_K +: W_K] <= s_k;
                        if (s_last || idx == IW'(C - 1)) begin
                            lanes_used <= LW'(idx) + LW'(1);
                            idx        <= '0;
                            tcnt       <= '0;
                            s_ready    <= 1'b0;
                            mul_en     <= 1'b1;
                            state      <= StIssue;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                StIssue: begin
                    if (mul_valid) begin
                        y_out   <= mul_y;
                        y_valid <= 1'b1;
                        mul_en  <= 1'b0;
                        state   <= StDrain;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        mul_en <= 1'b0;
                        state  <= StDrain;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                StDrain: begin
                    // Clearing here zero-pads whatever partial vector comes next.
                    x_vec   <= '0;
                    k_vec   <= '0;
                    s_ready <= 1'b1;
                    mul_en  <= 1'b0;
                    state   <= StFill;
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_operand_loader.sv
// Table-driven directed bench for vec_operand_loader (C=8, 8-bit elements, TIMEOUT=16).
module tb_vec_operand_loader;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_x = '0;
    logic [7:0]  s_k = '0;
    logic        s_last = 1'b0;
    logic [63:0] x_vec;
    logic [63:0] k_vec;
    logic        mul_en;
    logic        mul_valid = 1'b0;
    logic [7:0]  mul_y = '0;
    logic [7:0]  y_out;
    logic        y_valid;
    logic [3:0]  lanes_used;
    logic        err;

    int n_vec  = 0;
    int n_fail = 0;

    vec_operand_loader #(.C(8), .W_X(8), .W_K(8), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x        (s_x),
        .s_k        (s_k),
        .s_last     (s_last),
        .x_vec      (x_vec),
        .k_vec      (k_vec),
        .mul_en     (mul_en),
        .mul_valid  (mul_valid),
        .mul_y      (mul_y),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .lanes_used (lanes_used),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] xs;
        logic [63:0] ks;
        int          n;
        bit          use_last;
        int          lat;       // ISSUE cycle carrying mul_valid; 0 = never
        logic [7:0]  y;
        logic [63:0] exp_x;
        logic [63:0] exp_k;
        int          exp_lu;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int budget = 40;
        while (s_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("s_ready_timeout", 64'(s_ready), 64'd1);
    endtask

    // Streams n pairs; afterwards keeps s_valid high with junk to probe ISSUE/DRAIN blocking.
    task automatic fill(input logic [63:0] xs, input logic [63:0] ks, input int n,
                        input bit use_last);
        for (int e = 0; e < n; e++) begin
            wait_ready();
            s_valid = 1'b1;
            s_x     = xs[e*8 +: 8];
            s_k     = ks[e*8 +: 8];
            s_last  = use_last && (e == n - 1);
            @(negedge clk);
        end
        s_x    = 8'hAA;
        s_k    = 8'h55;
        s_last = 1'b1;
    endtask

    task automatic do_issue(input int lat, input logic [7:0] y, input logic [63:0] exp_x,
                            input logic [63:0] exp_k, input int exp_lu, input bit exp_err);
        chk("issue_mul_en", 64'(mul_en), 64'd1);
        chk("issue_s_ready", 64'(s_ready), 64'd0);
        chk("lanes_used", 64'(lanes_used), 64'(exp_lu));
        chk("x_vec", x_vec, exp_x);
        chk("k_vec", k_vec, exp_k);
        for (int j = 1; j <= TIMEOUT; j++) begin
            if (j > 1) begin
                chk("x_hold", x_vec, exp_x);
                chk("k_hold", k_vec, exp_k);
                chk("mul_en_hold", 64'(mul_en), 64'd1);
            end
            if (lat == j) begin
                mul_valid = 1'b1;
                mul_y     = y;
            end
            @(negedge clk);
            mul_valid = 1'b0;
            if (lat == j) break;
        end
        // DRAIN cycle
        chk("drain_mul_en", 64'(mul_en), 64'd0);
        chk("drain_s_ready", 64'(s_ready), 64'd0);
        chk("y_valid", 64'(y_valid), 64'(lat != 0));
        if (lat != 0) chk("y_out", 64'(y_out), 64'(y));
        chk("err", 64'(err), 64'(exp_err));
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        chk("fill_s_ready", 64'(s_ready), 64'd1);
        chk("y_valid_pulse", 64'(y_valid), 64'd0);
        chk("lanes_used_hold", 64'(lanes_used), 64'(exp_lu));
        chk("x_cleared", x_vec, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit exp_err);
        fill(v.xs, v.ks, v.n, v.use_last);
        do_issue(v.lat, v.y, v.exp_x, v.exp_k, v.exp_lu, exp_err);
    endtask

    initial begin
        tbl[0] = '{64'h0807060504030201, 64'h0202020202020202, 8, 1'b0, 3, 8'd72,
                   64'h0807060504030201, 64'h0202020202020202, 8, 1'b0};
        tbl[1] = '{64'h0000000000FFFFFF, 64'h0000000000050505, 3, 1'b1, 2, 8'hF1,
                   64'h0000000000FFFFFF, 64'h0000000000050505, 3, 1'b0};
        tbl[2] = '{64'h0909090909090909, 64'h0101010101010101, 8, 1'b1, 1, 8'd72,
                   64'h0909090909090909, 64'h0101010101010101, 8, 1'b0};
        tbl[3] = '{64'h0000000000000004, 64'h0000000000000003, 1, 1'b1, 3, 8'd12,
                   64'h0000000000000004, 64'h0000000000000003, 1, 1'b0};
        tbl[4] = '{64'h000000000000FD07, 64'h0000000000000201, 2, 1'b1, 0, 8'h00,
                   64'h000000000000FD07, 64'h0000000000000201, 2, 1'b1};
        tbl[5] = '{64'h1716151413121110, 64'hFFFFFFFFFFFFFFFF, 8, 1'b0, 4, 8'h7F,
                   64'h1716151413121110, 64'hFFFFFFFFFFFFFFFF, 8, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_mul_en", 64'(mul_en), 64'd0);
        chk("rst_x_vec", x_vec, 64'd0);
        chk("rst_k_vec", k_vec, 64'd0);
        chk("rst_lanes_used", 64'(lanes_used), 64'd0);
        chk("rst_err_yv", {62'd0, err, y_valid}, 64'd0);
        chk("rst_y_out", 64'(y_out), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], tbl[i].exp_err);

        // Gapped stream; a stray mul_valid in FILL must be ignored.
        begin
            logic [7:0] xv[5] = '{8'h01, 8'hEE, 8'h02, 8'hEE, 8'h03};
            logic [7:0] kv[5] = '{8'h0A, 8'hEE, 8'h0B, 8'hEE, 8'h0C};
            wait_ready();
            for (int i = 0; i < 5; i++) begin
                s_valid   = (i % 2 == 0);
                s_x       = xv[i];
                s_k       = kv[i];
                s_last    = (i == 4);
                mul_valid = (i == 1);
                mul_y     = 8'h99;
                @(negedge clk);
                mul_valid = 1'b0;
                if (i < 4) chk("gap_no_y_valid", 64'(y_valid), 64'd0);
            end
            s_x    = 8'hAA;
            s_k    = 8'h55;
            do_issue(1, 8'h33, 64'h0000000000030201, 64'h00000000000C0B0A, 3, 1'b1);
        end

        // Reset while the multiplier is enabled
        fill(tbl[0].xs, tbl[0].ks, 8, 1'b0);
        chk("pre_rst_mul_en", 64'(mul_en), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        rstn    = 1'b0;
        #1;
        chk("mid_rst_mul_en", 64'(mul_en), 64'd0);
        chk("mid_rst_x_vec", x_vec, 64'd0);
        chk("mid_rst_k_vec", k_vec, 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rerst_s_ready", 64'(s_ready), 64'd1);
        run_vec(tbl[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_operand_loader.md
Name: vec_operand_loader

Overview:
- Upstream feeder for the C-lane vector multiply/reduce stage.
- Accepts (x, k) element pairs serially over a valid/ready stream and packs them into C-lane operand vectors. Short vectors are zero-padded.
- Once a vector is complete, it holds the operands stable, asserts the multiplier enable until the multiplier's valid pulse, captures the result, then re-arms for the next vector.

Parameters:
- C, 8, number of lanes per vector
- W_X, 8, data element width (signed)
- W_K, 8, coefficient element width (signed)
- TIMEOUT, 16, max ISSUE cycles to wait for mul_valid before aborting (≥4)

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  input element pair valid
- s_ready  out  1  loader can accept a pair this cycle
- s_x  in  W_X  signed data element
- s_k  in  W_K  signed coefficient element
- s_last  in  1  final pair of the current vector (may arrive before lane C-1)
- x_vec  out  C*W_X  packed data lanes to multiplier, lane i at [i*W_X +: W_X]
- k_vec  out  C*W_K  packed coefficient lanes, same packing
- mul_en  out  1  multiplier enable
- mul_valid  in  1  multiplier result-valid pulse
- mul_y  in  W_X  multiplier result, sampled when mul_valid=1
- y_out  out  W_X  registered captured result
- y_valid  out  1  one-cycle pulse, y_out updated
- lanes_used  out  $clog2(C)+1  lanes filled in the vector just issued (1..C)
- err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (async, rstn=0):
  - State goes to FILL, lane index = 0.
  - x_vec, k_vec, y_out and lanes_used go to 0; mul_en, y_valid and err go to 0.
  - s_ready is 0 while rstn=0 and becomes 1 on the first clock after release.
- Reset mid-operation aborts everything immediately with no result pulse.
- FILL:
  - s_ready=1, mul_en=0.
  - A transfer occurs when s_valid && s_ready. On transfer, lane[idx] ← (s_x, s_k) and idx increments.
  - If the transfer is at idx==C-1 or has s_last=1: set lanes_used=idx+1, reset idx to 0, and go to ISSUE on the next edge.
  - s_last at idx==C-1 is equivalent to a full vector.
- ISSUE:
  - s_ready=0, mul_en=1. x_vec and k_vec are held bit-stable for the whole state.
  - mul_en is first high in the cycle after the final FILL transfer, so fill-to-enable latency is 1 cycle.
  - On an edge where mul_valid=1:
    - y_out ← mul_y, y_valid=1 for exactly the following cycle.
    - Go to DRAIN.
  - If mul_valid is not seen within TIMEOUT cycles in ISSUE: set err=1, go to DRAIN, no y_valid.
  - mul_valid outside ISSUE is ignored.
- DRAIN:
  - Exactly 1 cycle with mul_en=0 and s_ready=0. This guarantees the multiplier's internal counter resets between vectors.
  - All lanes are cleared to 0 so the next partial vector is zero-padded.
  - Next state is FILL.
- Throughput: a full vector costs C fill cycles, then ISSUE (3 cycles with the current multiplier latency), then 1 DRAIN cycle.
- lanes_used holds its value until the next ISSUE entry.
- No arithmetic is performed in this block. Elements pass through bit-exact; sign is preserved by the consumer.

Test Plan:
- Full vector, C=8: stream x=1..8, k=2 with s_valid held high; model mul_valid on the 3rd ISSUE cycle with mul_y=72 -> x_vec lanes are 1..8 and k_vec lanes are all 2, stable throughout ISSUE. mul_en is high 1 cycle after the 8th transfer and low in DRAIN. y_out=72 with a 1-cycle y_valid pulse, lanes_used=8, s_ready=1 again 2 cycles after mul_valid.
- Short vector: 3 pairs (x=-1,k=5), the 3rd with s_last=1 -> lanes 0..2 hold (-1,5), lanes 3..7 are 0, lanes_used=3.
- Back-pressure/gaps: s_valid toggling 1,0,1,0 during FILL -> only cycles with s_valid=1 write lanes. No transfers occur during ISSUE or DRAIN even with s_valid held high (s_ready=0).
- Timeout: suppress mul_valid -> after 16 ISSUE cycles err=1 (sticky), no y_valid, mul_en drops, loader returns to FILL and accepts the next vector.
- Reset mid-ISSUE: drop rstn while mul_en=1 -> mul_en, x_vec and k_vec are 0 immediately (asynchronous). After release, the loader is in FILL with idx=0, and a subsequent full vector completes normally.
- Zero-padding after a prior full vector: full vector x=9 in all lanes, then a 1-element vector x=4,k=3,s_last -> lanes 1..7 are 0 (no stale 9s), lanes_used=1.
